// File: rtl/spi_bus_arbiter_if.sv
// Client-side and spi_master-side signals of the two-client SPI bus arbiter.
// The arbiter connects through the slave modport; clients and the SPI engine drive the master side.
interface spi_bus_arbiter_if;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] start;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic [1:0] done;
    logic [7:0] rdata;
    logic       timeout_err;
    logic       spi_start;
    logic [7:0] spi_data_in;
    logic       spi_done;
    logic [7:0] spi_data_out;
    logic [1:0] spi_cs_n;

    modport master (
        output req, start, wdata0, wdata1, spi_done, spi_data_out,
        input  gnt, done, rdata, timeout_err, spi_start, spi_data_in, spi_cs_n
    );

    modport slave (
        input  req, start, wdata0, wdata1, spi_done, spi_data_out,
        output gnt, done, rdata, timeout_err, spi_start, spi_data_in, spi_cs_n
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of one spi_master byte engine shared by two clients, with
// chip-select setup/gap timing, byte start/done routing and an idle-owner watchdog.
module spi_bus_arbiter #(
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 4,
    parameter int TIMEOUT  = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_bus_arbiter_if.slave bus
);
    localparam int SETUP_W = $clog2(CS_SETUP + 1);
    localparam int GAP_W   = $clog2(CS_GAP + 1);
    localparam int WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(CS_SETUP - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(CS_GAP - 1);
    localparam logic [WD_W-1:0]    WD_LAST    = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, OWN, GAP} state_e;

    state_e             state_q;
    logic               owner_q;
    logic               rr_last_q;
    logic               inflight_q;
    logic [SETUP_W-1:0] setup_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [WD_W-1:0]    wd_cnt_q;
    logic [1:0]         gnt_q;
    logic [1:0]         cs_n_q;
    logic [1:0]         done_q;
    logic [7:0]         rdata_q;
    logic               spi_start_q;
    logic [7:0]         spi_data_in_q;
    logic               timeout_err_q;

    logic       winner_d;
    logic       owner_req;
    logic       owner_start;
    logic [7:0] owner_wdata;
    logic       wd_expire;

    // Both requesting: the client that did not win last time goes next.
    assign winner_d    = (bus.req == 2'b11) ? ~rr_last_q : bus.req[1];
    assign owner_req   = bus.req[owner_q];
    assign owner_start = bus.start[owner_q];
    assign owner_wdata = owner_q ? bus.wdata1 : bus.wdata0;
    assign wd_expire   = (TIMEOUT > 0) && (wd_cnt_q == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            rr_last_q     <= 1'b1;
            inflight_q    <= 1'b0;
            setup_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            wd_cnt_q      <= '0;
            gnt_q         <= 2'b00;
            cs_n_q        <= 2'b11;
            done_q        <= 2'b00;
            rdata_q       <= 8'h00;
            spi_start_q   <= 1'b0;
            spi_data_in_q <= 8'h00;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            spi_start_q   <= 1'b0;
            done_q        <= 2'b00;
            timeout_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        owner_q     <= winner_d;
                        rr_last_q   <= winner_d;
                        cs_n_q      <= winner_d ? 2'b01 : 2'b10;
                        setup_cnt_q <= '0;
                        state_q     <= SETUP;
                    end
                end

                SETUP: begin
                    if (setup_cnt_q == SETUP_LAST) begin
                        gnt_q    <= owner_q ? 2'b10 : 2'b01;
                        wd_cnt_q <= '0;
                        state_q  <= OWN;
                    end else begin
                        setup_cnt_q <= setup_cnt_q + SETUP_W'(1);
                    end
                end

                OWN: begin
                    if (inflight_q) begin
                        // A byte in flight always completes, even if req drops or the watchdog is due.
                        if (bus.spi_done) begin
                            done_q     <= owner_q ? 2'b10 : 2'b01;
                            rdata_q    <= bus.spi_data_out;
                            inflight_q <= 1'b0;
                            wd_cnt_q   <= '0;
                        end
                    end else if (!owner_req) begin
                        gnt_q     <= 2'b00;
                        cs_n_q    <= 2'b11;
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end else if (owner_start) begin
                        spi_start_q   <= 1'b1;
                        spi_data_in_q <= owner_wdata;
                        inflight_q    <= 1'b1;
                        wd_cnt_q      <= '0;
                    end else if (bus.spi_done) begin
                        wd_cnt_q <= '0;
                    end else if (wd_expire) begin
                        gnt_q         <= 2'b00;
                        cs_n_q        <= 2'b11;
                        gap_cnt_q     <= '0;
                        timeout_err_q <= 1'b1;
                        state_q       <= GAP;
                    end else if (TIMEOUT > 0) begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
                end

                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.spi_cs_n    = cs_n_q;
    assign bus.done        = done_q;
    assign bus.rdata       = rdata_q;
    assign bus.spi_start   = spi_start_q;
    assign bus.spi_data_in = spi_data_in_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: a table-driven transaction, directed corner sequences and
// randomized traffic, all checked cycle by cycle against a phase/deadline reference model.
module tb_spi_bus_arbiter;
    localparam int CS_SETUP = 2;
    localparam int CS_GAP   = 4;
    localparam int TIMEOUT  = 8;

    localparam int P_IDLE  = 0;
    localparam int P_SETUP = 1;
    localparam int P_OWN   = 2;
    localparam int P_GAP   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_bus_arbiter_if bus ();

    spi_bus_arbiter #(
        .CS_SETUP(CS_SETUP),
        .CS_GAP  (CS_GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_spi_start = 0;
    int n_done = 0;
    int n_terr = 0;

    // Stimulus for the next clock; start and spi_done are one-cycle pulses.
    logic [1:0] d_req, d_start;
    logic [7:0] d_wd0, d_wd1, d_sdo;
    logic       d_sd;

    // Reference model: phase plus cycles remaining, and a queue of bytes on the wire.
    int         m_phase, m_left, m_owner, m_last, m_idle;
    logic [7:0] m_pend[$];
    logic [1:0] e_gnt, e_cs_n, e_done;
    logic       e_ss, e_terr;
    logic [7:0] e_sdi, e_rdata;

    int         spi_cd;
    logic [7:0] spi_byte;

    typedef struct {
        logic [1:0] req;
        logic [1:0] start;
        logic [7:0] wd0;
        logic       sd;
        logic [7:0] sdo;
        logic [1:0] gnt;
        logic [1:0] cs_n;
        logic       ss;
        logic [7:0] sdi;
        logic [1:0] done;
        logic [7:0] rdata;
        logic       terr;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic [1:0] req, logic [1:0] start, logic [7:0] wd0, logic sd,
                                logic [7:0] sdo, logic [1:0] gnt, logic [1:0] cs_n, logic ss,
                                logic [7:0] sdi, logic [1:0] done, logic [7:0] rdata, logic terr);
        vec_t v;
        v.req = req; v.start = start; v.wd0 = wd0; v.sd = sd; v.sdo = sdo;
        v.gnt = gnt; v.cs_n = cs_n; v.ss = ss; v.sdi = sdi; v.done = done;
        v.rdata = rdata; v.terr = terr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] dut_outs();
        return {bus.gnt, bus.spi_cs_n, bus.spi_start, bus.spi_data_in,
                bus.done, bus.rdata, bus.timeout_err};
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_left = 0; m_owner = 0; m_last = 1; m_idle = 0;
        m_pend.delete();
        e_gnt = 2'b00; e_cs_n = 2'b11; e_done = 2'b00; e_ss = 1'b0; e_terr = 1'b0;
        e_sdi = 8'h00; e_rdata = 8'h00;
    endtask

    task automatic model_release(input logic forced);
        m_phase = P_GAP; m_left = CS_GAP;
        e_gnt = 2'b00; e_cs_n = 2'b11; e_terr = forced;
    endtask

    task automatic model_step(input logic [1:0] req, input logic [1:0] start, input logic [7:0] wd0,
                              input logic [7:0] wd1, input logic sd, input logic [7:0] sdo);
        e_ss = 1'b0; e_done = 2'b00; e_terr = 1'b0;
        case (m_phase)
            P_IDLE: if (req != 2'b00) begin
                if (req == 2'b11) m_owner = 1 - m_last;
                else              m_owner = req[1] ? 1 : 0;
                m_last = m_owner;
                m_phase = P_SETUP; m_left = CS_SETUP;
                e_cs_n = 2'b11; e_cs_n[m_owner] = 1'b0;
            end
            P_SETUP: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = P_OWN; m_idle = 0;
                    e_gnt = 2'b00; e_gnt[m_owner] = 1'b1;
                end
            end
            P_OWN: begin
                if (m_pend.size() != 0) begin
                    if (sd) begin
                        void'(m_pend.pop_front());
                        e_done[m_owner] = 1'b1; e_rdata = sdo; m_idle = 0;
                    end
                end else if (!req[m_owner]) begin
                    model_release(1'b0);
                end else if (start[m_owner]) begin
                    e_sdi = (m_owner == 1) ? wd1 : wd0;
                    m_pend.push_back(e_sdi);
                    e_ss = 1'b1; m_idle = 0;
                end else if (sd) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (TIMEOUT > 0 && m_idle == TIMEOUT) model_release(1'b1);
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = P_IDLE;
            end
        endcase
    endtask

    task automatic cycle();
        bus.req = d_req; bus.start = d_start; bus.wdata0 = d_wd0; bus.wdata1 = d_wd1;
        bus.spi_done = d_sd; bus.spi_data_out = d_sdo;
        model_step(d_req, d_start, d_wd0, d_wd1, d_sd, d_sdo);
        d_start = 2'b00; d_sd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("model", 32'(dut_outs()), 32'({e_gnt, e_cs_n, e_ss, e_sdi, e_done, e_rdata, e_terr}));
        check("invariant", 32'(($countones(bus.gnt) <= 1) && ($countones(~bus.spi_cs_n) <= 1)
                               && ((bus.gnt & bus.spi_cs_n) == 2'b00)), 32'd1);
        if (bus.spi_start) n_spi_start++;
        if (bus.done != 2'b00) n_done++;
        if (bus.timeout_err) n_terr++;
    endtask

    task automatic drive_idle();
        d_req = 2'b00; d_start = 2'b00; d_wd0 = 8'h00; d_wd1 = 8'h00; d_sd = 1'b0; d_sdo = 8'h00;
        bus.req = 2'b00; bus.start = 2'b00; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
        bus.spi_done = 1'b0; bus.spi_data_out = 8'h00;
        spi_cd = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int budget);
        int n = 0;
        while (bus.gnt == 2'b00 && n < budget) begin
            cycle();
            n++;
        end
        check("grant_wait", 32'(bus.gnt != 2'b00), 32'd1);
    endtask

    task automatic idle_out(input int cycles);
        d_req = 2'b00;
        repeat (cycles) cycle();
    endtask

    initial begin
        int k, hi, s0, d0, t0;

        drive_idle();
        model_reset();
        do_reset();
        check("reset_outs", 32'(dut_outs()), 32'({2'b00, 2'b11, 1'b0, 8'h00, 2'b00, 8'h00, 1'b0}));

        // Single-client 3-byte transaction, one row per clock.
        vecs[0]  = mk(2'b01, 2'b00, 8'h00, 0, 8'h00, 2'b00, 2'b10, 0, 8'h00, 2'b00, 8'h00, 0);
        vecs[1]  = mk(2'b01, 2'b00, 8'h00, 0, 8'h00, 2'b00, 2'b10, 0, 8'h00, 2'b00, 8'h00, 0);
        vecs[2]  = mk(2'b01, 2'b00, 8'h00, 0, 8'h00, 2'b01, 2'b10, 0, 8'h00, 2'b00, 8'h00, 0);
        vecs[3]  = mk(2'b01, 2'b01, 8'hBB, 0, 8'h00, 2'b01, 2'b10, 1, 8'hBB, 2'b00, 8'h00, 0);
        vecs[4]  = mk(2'b01, 2'b00, 8'h00, 0, 8'h00, 2'b01, 2'b10, 0, 8'hBB, 2'b00, 8'h00, 0);
        vecs[5]  = mk(2'b01, 2'b00, 8'h00, 1, 8'h12, 2'b01, 2'b10, 0, 8'hBB, 2'b01, 8'h12, 0);
        vecs[6]  = mk(2'b01, 2'b01, 8'h00, 0, 8'h00, 2'b01, 2'b10, 1, 8'h00, 2'b00, 8'h12, 0);
        vecs[7]  = mk(2'b01, 2'b00, 8'h00, 1, 8'h34, 2'b01, 2'b10, 0, 8'h00, 2'b01, 8'h34, 0);
        vecs[8]  = mk(2'b01, 2'b01, 8'h00, 0, 8'h00, 2'b01, 2'b10, 1, 8'h00, 2'b00, 8'h34, 0);
        vecs[9]  = mk(2'b01, 2'b00, 8'h00, 1, 8'h56, 2'b01, 2'b10, 0, 8'h00, 2'b01, 8'h56, 0);
        for (int i = 10; i < 16; i++)
            vecs[i] = mk(2'b00, 2'b00, 8'h00, 0, 8'h00, 2'b00, 2'b11, 0, 8'h00, 2'b00, 8'h56, 0);

        for (int i = 0; i < 16; i++) begin
            d_req = vecs[i].req; d_start = vecs[i].start; d_wd0 = vecs[i].wd0;
            d_sd = vecs[i].sd; d_sdo = vecs[i].sdo;
            cycle();
            check($sformatf("vec%0d", i), 32'(dut_outs()),
                  32'({vecs[i].gnt, vecs[i].cs_n, vecs[i].ss, vecs[i].sdi,
                       vecs[i].done, vecs[i].rdata, vecs[i].terr}));
        end

        // Simultaneous requests alternate ownership.
        do_reset();
        d_req = 2'b11;
        k = 0;
        while (bus.gnt == 2'b00 && k < 20) begin cycle(); k++; end
        check("alt_lat0", 32'(k), 32'(CS_SETUP + 1));
        check("alt_first", 32'(bus.gnt), 32'(2'b01));
        d_req = 2'b10;
        cycle();
        check("alt_release", 32'({bus.gnt, bus.spi_cs_n}), 32'({2'b00, 2'b11}));
        k = 0; hi = 1;
        while (bus.gnt != 2'b10 && k < 30) begin
            cycle();
            k++;
            if (bus.spi_cs_n == 2'b11) hi++;
        end
        check("alt_lat1", 32'(k), 32'(CS_GAP + 1 + CS_SETUP));
        check("alt_gap_cs_high", 32'(hi), 32'(CS_GAP + 1));
        idle_out(CS_GAP + 2);
        d_req = 2'b11;
        wait_grant(20);
        check("alt_second", 32'(bus.gnt), 32'(2'b01));
        idle_out(CS_GAP + 2);
        d_req = 2'b11;
        wait_grant(20);
        check("alt_third", 32'(bus.gnt), 32'(2'b10));

        // Non-owner and in-flight starts are dropped.
        do_reset();
        d_req = 2'b01;
        wait_grant(20);
        s0 = n_spi_start;
        d_start = 2'b10; d_wd1 = 8'h77; cycle();
        check("ill_nonowner", 32'(bus.spi_start), 32'd0);
        d_start = 2'b01; d_wd0 = 8'h11; cycle();
        check("ill_accept1", 32'({bus.spi_start, bus.spi_data_in}), 32'({1'b1, 8'h11}));
        d_start = 2'b01; d_wd0 = 8'h22; cycle();
        check("ill_inflight", 32'({bus.spi_start, bus.spi_data_in}), 32'({1'b0, 8'h11}));
        d_start = 2'b10; cycle();
        d_sd = 1'b1; d_sdo = 8'h99; cycle();
        check("ill_done", 32'({bus.done, bus.rdata}), 32'({2'b01, 8'h99}));
        d_start = 2'b01; d_wd0 = 8'h33; cycle();
        check("ill_accept2", 32'({bus.spi_start, bus.spi_data_in}), 32'({1'b1, 8'h33}));
        d_sd = 1'b1; d_sdo = 8'h44; cycle();
        check("ill_count", 32'(n_spi_start - s0), 32'd2);

        // Request dropped while a byte is on the wire.
        do_reset();
        d_req = 2'b01;
        wait_grant(20);
        d_start = 2'b01; d_wd0 = 8'hC3; cycle();
        check("drop_start", 32'({bus.spi_start, bus.spi_data_in}), 32'({1'b1, 8'hC3}));
        d_req = 2'b00; cycle();
        check("drop_hold", 32'({bus.gnt, bus.spi_cs_n}), 32'({2'b01, 2'b10}));
        d_sd = 1'b1; d_sdo = 8'hA5; cycle();
        check("drop_done", 32'({bus.gnt, bus.done, bus.rdata}), 32'({2'b01, 2'b01, 8'hA5}));
        cycle();
        check("drop_release", 32'({bus.gnt, bus.spi_cs_n}), 32'({2'b00, 2'b11}));

        // Watchdog releases an idle owner; the waiting client is served next.
        do_reset();
        d_req = 2'b01;
        wait_grant(20);
        d_req = 2'b11;
        k = 1;
        while (bus.gnt == 2'b01 && k < 40) begin
            cycle();
            if (bus.gnt == 2'b01) k++;
        end
        check("wd_len", 32'(k), 32'(TIMEOUT));
        check("wd_release", 32'({bus.gnt, bus.spi_cs_n, bus.timeout_err}), 32'({2'b00, 2'b11, 1'b1}));
        cycle();
        check("wd_pulse", 32'(bus.timeout_err), 32'd0);
        wait_grant(20);
        check("wd_next", 32'(bus.gnt), 32'(2'b10));

        // Asynchronous reset with a byte in flight.
        do_reset();
        d_req = 2'b01;
        wait_grant(20);
        d_start = 2'b01; d_wd0 = 8'h5A; cycle();
        check("rst_pre", 32'(bus.spi_start), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'(2'b00));
        check("rst_cs", 32'(bus.spi_cs_n), 32'(2'b11));
        check("rst_pulses", 32'({bus.spi_start, bus.done, bus.timeout_err}), 32'd0);
        model_reset();
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = n_spi_start; d0 = n_done; t0 = n_terr;
        repeat (8) cycle();
        check("rst_quiet", 32'((n_spi_start - s0) + (n_done - d0) + (n_terr - t0)), 32'd0);
        check("rst_idle", 32'({bus.gnt, bus.spi_cs_n}), 32'({2'b00, 2'b11}));

        // Randomized traffic with a responsive SPI engine.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (bus.spi_start) begin
                spi_cd = $urandom_range(1, 4);
                spi_byte = 8'($urandom);
            end
            if (spi_cd > 0) begin
                spi_cd--;
                if (spi_cd == 0) begin
                    d_sd = 1'b1;
                    d_sdo = spi_byte;
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (!d_req[c]) begin
                    if ($urandom_range(0, 3) == 0) d_req[c] = 1'b1;
                end else if (e_gnt[c] && $urandom_range(0, 9) == 0) begin
                    d_req[c] = 1'b0;
                end
                d_start[c] = d_req[c] && ($urandom_range(0, 2) == 0);
            end
            d_wd0 = 8'($urandom);
            d_wd1 = 8'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one spi_master byte engine between two clients, e.g. mpu_driver (client 0) and a second SPI peripheral or config sequencer (client 1).
- Each client owns its chip-select for a whole multi-byte transaction.
- The arbiter handles CS setup/gap timing, round-robin ownership, byte start/done routing, and a watchdog for stalled owners.
- Sits between the clients and the single spi_master instance.

Parameters:
- CS_SETUP, 2, cycles between CS assertion and grant (min 1).
- CS_GAP, 4, cycles CS held high after release before the next grant cycle can begin (min 1).
- TIMEOUT, 65535, idle-owner cycles before forced release; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  per-client transaction request; hold high for the whole CS window.
- gnt  out  2  one-hot ownership; bytes may be started only while gnt[i]=1.
- start  in  2  per-client byte-start pulse.
- wdata0  in  8  client 0 byte to send.
- wdata1  in  8  client 1 byte to send.
- done  out  2  per-client byte-complete pulse, 1 cycle.
- rdata  out  8  received byte, valid with done.
- timeout_err  out  1  1-cycle pulse on watchdog release.
- spi_start  out  1  to spi_master start.
- spi_data_in  out  8  to spi_master data_in.
- spi_done  in  1  from spi_master done.
- spi_data_out  in  8  from spi_master data_out.
- spi_cs_n  out  2  per-client chip select, active low.

Behaviour:
- Reset values (asynchronous, any state): gnt=0, done=0, rdata=0, timeout_err=0, spi_start=0, spi_data_in=0, spi_cs_n=2'b11, state=IDLE, rr_last=1 (client 0 wins first), inflight=0, counters=0.
- IDLE → SETUP when req≠0.
  - Winner: the sole requester; if both request, the client ≠ rr_last.
  - Owner register and rr_last load with the winner.
  - spi_cs_n[owner]=0 from the next cycle.
- SETUP: count CS_SETUP cycles, then go to OWN with gnt[owner]=1. Request rdata is stable during SETUP.
- OWN, byte start: start[owner]=1 and inflight=0 → next cycle spi_start=1 (exactly one cycle) and spi_data_in=wdata of owner; inflight←1.
- OWN, ignored starts:
  - start from the non-owner is ignored.
  - start while inflight=1 is ignored.
  - start in any state other than OWN is ignored.
- OWN, byte completion: spi_done=1 → next cycle done[owner]=1 and rdata=spi_data_out; inflight←0. spi_done with inflight=0 is ignored.
- OWN, release: req[owner]=0 and inflight=0 → go to GAP next cycle with gnt=0 and spi_cs_n=2'b11. If req drops while inflight=1, the byte finishes, done is still delivered, and then release occurs.
- Watchdog (TIMEOUT>0):
  - Counts OWN cycles with inflight=0 and no accepted start; resets on any accepted start or spi_done.
  - At count==TIMEOUT: forced release as above, timeout_err pulses 1 cycle.
  - An inflight byte is never aborted.
- GAP: count CS_GAP cycles, then go to IDLE. Requests arriving during GAP wait; round-robin is re-evaluated in IDLE, so a continuously requesting other client gets the bus next.
- Invariants:
  - At most one gnt bit and one spi_cs_n bit active.
  - gnt[i]=1 implies spi_cs_n[i]=0.
  - spi_cs_n[i]=0 only in SETUP/OWN.
- Single-client byte latency: start → spi_start is 1 cycle; spi_done → done is 1 cycle.
- Counter widths sized by $clog2 of the respective parameter+1.

Test Plan:
- Reset: hold rst_n=0 mid-OWN with a byte in flight → gnt=0, spi_cs_n=2'b11, spi_start=0, done=0 immediately; after release, IDLE with no spurious pulses.
- Single-client 3-byte transaction: req0=1; gnt[0] rises CS_SETUP=2 cycles after spi_cs_n[0] falls; start bytes 0xBB, 0x00, 0x00 with the model returning 0x12, 0x34, 0x56 → three spi_start pulses carrying 0xBB, 0x00, 0x00; done[0] pulses carry rdata 0x12, 0x34, 0x56; req0=0 → spi_cs_n=11, then ≥4 gap cycles.
- Simultaneous req=2'b11 from reset → client 0 granted first; on its release, client 1 granted after CS_GAP=4 cycles; next simultaneous request → client 0 again (alternation).
- Illegal starts: start[1] while client 0 owns, and a second start[0] while inflight → no extra spi_start; the spi_start count equals the accepted starts exactly.
- req0 dropped one cycle after a start → spi_done still produces done[0] with the correct rdata (e.g. 0xA5), then CS deasserts.
- Watchdog with TIMEOUT=8: owner holds req with no starts → after 8 idle OWN cycles gnt=0, spi_cs_n=11, timeout_err=1 for exactly 1 cycle; pending client 1 is then granted after the gap.
